// File: rtl/ram_responder.sv
// ---------------------------------------------------------------------------
// ram_responder
//
// Byte-addressed RAM slave with a four-phase style handshake. The initiator
// raises RAM_enable and holds it; the block latches the request, inserts
// WAIT_CYCLES wait states, performs the access and raises MFC. MFC stays
// high until the initiator drops RAM_enable. Multi-byte data is big-endian.
//
// Ports:
//   Clk        in   sole clock, rising edge
//   Clr        in   synchronous active-high reset
//   RAM_enable in   request, held high until MFC is observed
//   RAM_OpCode in   [2] 1=write/0=read, [1:0] size (byte/half/word/reserved),
//                   [3] sign-extend loads, [5:4] ignored
//   Address    in   byte address (ADDR_WIDTH bits, wraps modulo array size)
//   DataIn     in   write data, right-justified
//   DataOut    out  read data, right-justified and zero/sign-extended
//   MFC        out  memory function complete
//   MisAlign   out  misaligned-access flag, valid while MFC is high
//
// Configuration macro: RAM_ALIGN_CHECK_EN
//   defined   -> misaligned halfword/word accesses are flagged and suppressed
//   undefined -> MisAlign stays 0 and misaligned accesses use consecutive
//                bytes from Address with wrap-around
// ---------------------------------------------------------------------------
module ram_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  Clk,
    input  logic                  Clr,
    input  logic                  RAM_enable,
    input  logic [5:0]            RAM_OpCode,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [31:0]           DataIn,
    output logic [31:0]           DataOut,
    output logic                  MFC,
    output logic                  MisAlign
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic                  sext_q, sext_d;
    logic [1:0]            size_q, size_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic [31:0]           dout_q, dout_d;
    logic                  mfc_q, mfc_d;
    logic                  mis_q, mis_d;
    logic                  memWe;

    logic [7:0]            memArray [DEPTH];

    // Byte addresses of the (up to) four bytes touched, wrapping naturally
    // because they are ADDR_WIDTH bits wide.
    logic [ADDR_WIDTH-1:0] addr1, addr2, addr3;
    logic [7:0]            b0, b1, b2, b3;
    logic                  signBit;
    logic [31:0]           readData;
    logic                  misAligned;

    assign addr1 = addr_q + ADDR_WIDTH'(1);
    assign addr2 = addr_q + ADDR_WIDTH'(2);
    assign addr3 = addr_q + ADDR_WIDTH'(3);

    assign b0 = memArray[addr_q];
    assign b1 = memArray[addr1];
    assign b2 = memArray[addr2];
    assign b3 = memArray[addr3];

    // Big-endian: the most significant byte of a byte or halfword load is
    // always the byte at the base address, so it carries the sign.
    assign signBit = sext_q & b0[7];

    // Assemble the right-justified load value for the latched size.
    always_comb begin
        readData = 32'h0;
        case (size_q)
            2'd0:    readData = {{24{signBit}}, b0};
            2'd1:    readData = {{16{signBit}}, b0, b1};
            2'd2:    readData = {b0, b1, b2, b3};
            default: readData = 32'h0;
        endcase
    end

`ifdef RAM_ALIGN_CHECK_EN
    assign misAligned = ((size_q == 2'd1) && addr_q[0]) ||
                        ((size_q == 2'd2) && (addr_q[1:0] != 2'b00));
`else
    assign misAligned = 1'b0;
`endif

    // Next-state logic for the IDLE -> WAIT -> DONE handshake. Request fields
    // are captured only in IDLE, so anything the initiator does on the bus
    // afterwards has no effect on the access in flight.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        sext_d  = sext_q;
        size_d  = size_q;
        addr_d  = addr_q;
        data_d  = data_q;
        dout_d  = dout_q;
        mfc_d   = mfc_q;
        mis_d   = mis_q;
        memWe   = 1'b0;

        case (state_q)
            IDLE: begin
                if (RAM_enable) begin
                    write_d = RAM_OpCode[2];
                    sext_d  = RAM_OpCode[3];
                    size_d  = RAM_OpCode[1:0];
                    addr_d  = Address;
                    data_d  = DataIn;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (cnt_q == 4'd0) begin
                    mfc_d   = 1'b1;
                    state_d = DONE;
                    if (misAligned) begin
                        mis_d = 1'b1;
                    end else if (write_q) begin
                        memWe = 1'b1;
                    end else begin
                        dout_d = readData;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            DONE: begin
                // Requests are never accepted here; the earliest new request
                // is taken on the edge after the return to IDLE.
                if (!RAM_enable) begin
                    mfc_d   = 1'b0;
                    mis_d   = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers. Clr wins over everything, including a
    // request arriving on the same edge or an access in its wait states.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            sext_q  <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            data_q  <= 32'h0;
            dout_q  <= 32'h0;
            mfc_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            sext_q  <= sext_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            dout_q  <= dout_d;
            mfc_q   <= mfc_d;
            mis_q   <= mis_d;
        end
    end

    // Storage array. It has no reset so its contents survive Clr; a write is
    // committed only on the MFC-rising edge and is dropped if Clr coincides.
    always_ff @(posedge Clk) begin
        if (!Clr && memWe) begin
            case (size_q)
                2'd0: begin
                    memArray[addr_q] <= data_q[7:0];
                end
                2'd1: begin
                    memArray[addr_q] <= data_q[15:8];
                    memArray[addr1]  <= data_q[7:0];
                end
                2'd2: begin
                    memArray[addr_q] <= data_q[31:24];
                    memArray[addr1]  <= data_q[23:16];
                    memArray[addr2]  <= data_q[15:8];
                    memArray[addr3]  <= data_q[7:0];
                end
                default: begin
                end
            endcase
        end
    end

    assign DataOut  = dout_q;
    assign MFC      = mfc_q;
    assign MisAlign = mis_q;

endmodule
